// File: rtl/oam_dma.sv
// oam_dma: NES sprite DMA engine.
// A CPU write to DMA_REG halts the CPU. The engine then copies 256 bytes from
// page {page,8'h00} to OAM_PORT. It alternates read (get) and write (put) cycles.
// Optional build macro OAM_DMA_ALIGN_EN adds a one-cycle ALIGN state. With it,
// every READ lands on a get cycle (parity 0).
module oam_dma #(
  parameter logic [15:0] DMA_REG  = 16'h4014,
  parameter logic [15:0] OAM_PORT = 16'h2004
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  input  logic        cpu_wen,
  output logic        cpu_rdy,
  output logic        dma_busy,
  output logic [15:0] dma_addr,
  output logic        dma_ren,
  output logic        dma_wen,
  output logic [7:0]  dma_wdata,
  input  logic [7:0]  dma_rdata
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HALT  = 3'd1,
    S_READ  = 3'd3,
    S_WRITE = 3'd4
`ifdef OAM_DMA_ALIGN_EN
    , S_ALIGN = 3'd2
`endif
  } state_t;

  state_t     state_reg, state_next;
  logic [7:0] page_reg, page_next;
  logic [7:0] idx_reg, idx_next;

`ifdef OAM_DMA_ALIGN_EN
  // Free-running get/put phase: 0 = get cycle, 1 = put cycle.
  logic parity_reg;

  // Toggle the bus phase every cycle from reset.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) parity_reg <= 1'b0;
    else       parity_reg <= ~parity_reg;
  end
`endif

  // State, source page and byte index registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_reg <= S_IDLE;
      page_reg  <= 8'h00;
      idx_reg   <= 8'h00;
    end else begin
      state_reg <= state_next;
      page_reg  <= page_next;
      idx_reg   <= idx_next;
    end
  end

  // Next-state logic.
  // A trigger is only accepted in IDLE, so the page cannot be re-latched mid-transfer.
  always_comb begin
    state_next = state_reg;
    page_next  = page_reg;
    idx_next   = idx_reg;
    case (state_reg)
      S_IDLE: begin
        if (cpu_wen && (cpu_addr == DMA_REG)) begin
          page_next  = cpu_wdata;
          idx_next   = 8'h00;
          state_next = S_HALT;
        end
      end
      S_HALT: begin
`ifdef OAM_DMA_ALIGN_EN
        // A HALT on a get cycle would put READ on a put cycle.
        // In that case insert one dummy cycle.
        state_next = parity_reg ? S_READ : S_ALIGN;
`else
        state_next = S_READ;
`endif
      end
`ifdef OAM_DMA_ALIGN_EN
      S_ALIGN: state_next = S_READ;
`endif
      S_READ:  state_next = S_WRITE;
      S_WRITE: begin
        // The index wraps within the page; it never carries into page_reg.
        idx_next   = idx_reg + 8'd1;
        state_next = (idx_reg == 8'hFF) ? S_IDLE : S_READ;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Moore outputs decoded from the registered state.
  always_comb begin
    cpu_rdy   = 1'b0;
    dma_busy  = 1'b1;
    dma_addr  = 16'h0000;
    dma_ren   = 1'b0;
    dma_wen   = 1'b0;
    dma_wdata = 8'h00;
    case (state_reg)
      S_IDLE: begin
        cpu_rdy  = 1'b1;
        dma_busy = 1'b0;
      end
      S_READ: begin
        dma_ren  = 1'b1;
        dma_addr = {page_reg, idx_reg};
      end
      S_WRITE: begin
        dma_wen   = 1'b1;
        dma_addr  = OAM_PORT;
        dma_wdata = dma_rdata;
      end
      default: ;
    endcase
  end

endmodule
